// File: rtl/parking_pkg.sv
// Shared parking-lot definitions: slot count, default timing and the
// slot-vector type used by the filter, counter and display stages.
package parking_pkg;

    localparam int N_SLOTS          = 15;
    localparam int TICK_DIV_DEF     = 100_000;
    localparam int STABLE_TICKS_DEF = 10;

    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    localparam int PRESC_W = $clog2(TICK_DIV_DEF);
    localparam int CNT_W   = cnt_width(STABLE_TICKS_DEF);

    typedef logic [N_SLOTS-1:0] slot_vec_t;

endpackage

// File: rtl/slot_debounce_cell.sv
// One sensor channel: 2-flop synchronizer, agreement counter, debounced
// occupancy bit and arrive/depart pulse generation.
module slot_debounce_cell import parking_pkg::*; #(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int CNT_W        = cnt_width(STABLE_TICKS)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic car,
    output logic arrive,
    output logic depart,
    output logic fire
);

    logic [1:0]       sync_ff;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    assign sync = sync_ff[1];

    // Acceptance happens on the edge that consumes this tick.
    assign fire = tick && (sync != car)
               && (cnt == CNT_W'(STABLE_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            cnt     <= '0;
            car     <= 1'b0;
            arrive  <= 1'b0;
            depart  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            arrive  <= 1'b0;
            depart  <= 1'b0;
            if (tick) begin
                if (sync == car) begin
                    cnt <= '0;
                end else if (fire) begin
                    car    <= sync;
                    cnt    <= '0;
                    arrive <= sync;
                    depart <= ~sync;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/slot_sensor_filter.sv
// Slot sensor front end: shared sample prescaler, one debounce cell per
// slot, and a registered OR of all arrive/depart pulses.
module slot_sensor_filter #(
    parameter int N_SLOTS      = parking_pkg::N_SLOTS,
    parameter int TICK_DIV     = parking_pkg::TICK_DIV_DEF,
    parameter int STABLE_TICKS = parking_pkg::STABLE_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SLOTS-1:0] car_raw,
    output logic [N_SLOTS-1:0] car,
    output logic [N_SLOTS-1:0] arrive,
    output logic [N_SLOTS-1:0] depart,
    output logic               any_event
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = parking_pkg::cnt_width(STABLE_TICKS);

    logic [PW-1:0]      presc;
    logic               tick;
    logic [N_SLOTS-1:0] fire;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        slot_debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CW)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .raw    (car_raw[i]),
            .car    (car[i]),
            .arrive (arrive[i]),
            .depart (depart[i]),
            .fire   (fire[i])
        );
    end

    // Registered from the same acceptance condition so it lines up with
    // the pulses rather than trailing them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |fire;
        end
    end

endmodule

// File: tb/tb_slot_sensor_filter.sv
// Directed and random checks of slot_sensor_filter against a model that
// accepts a change once the last STABLE_TICKS tick samples all disagree.
module tb_slot_sensor_filter;

    localparam int N  = 15;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] car_raw;
    logic [N-1:0] car;
    logic [N-1:0] arrive;
    logic [N-1:0] depart;
    logic         any_event;

    slot_sensor_filter #(
        .N_SLOTS      (N),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .car_raw   (car_raw),
        .car       (car),
        .arrive    (arrive),
        .depart    (depart),
        .any_event (any_event)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [N-1:0]  s0, s1, mcar, ea, ed;
    logic [ST-1:0] hist [N];
    int            edges;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s0 = '0; s1 = '0; mcar = '0; ea = '0; ed = '0; edges = 0;
        for (int i = 0; i < N; i++) hist[i] = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] r);
        edges++;
        ea = '0; ed = '0;
        if (edges % TD == 0) begin
            for (int i = 0; i < N; i++) begin
                hist[i] = {hist[i][ST-2:0], s1[i]};
                if (hist[i] == {ST{~mcar[i]}}) begin
                    mcar[i] = ~mcar[i];
                    if (mcar[i]) ea[i] = 1'b1;
                    else         ed[i] = 1'b1;
                end
            end
        end
        s1 = s0;
        s0 = r;
    endtask

    task automatic step();
        logic [N-1:0] r;
        r = car_raw;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else        model_edge(r);
        chk("car", 32'(car), 32'(mcar));
        chk("arrive", 32'(arrive), 32'(ea));
        chk("depart", 32'(depart), 32'(ed));
        chk("event", 32'(any_event), 32'(|(ea | ed)));
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic async_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_car", 32'(car), 32'h0);
        chk("rst_pulses", 32'(arrive | depart), 32'h0);
        chk("rst_event", 32'(any_event), 32'h0);
        hold(cycles);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int arr_cyc;
        int ev_cyc;
        int seen;

        // Reset with every slot occupied, then release.
        rst_n   = 1'b0;
        car_raw = 15'h7FFF;
        model_reset();
        #2;
        hold(3);
        chk("t1_reset_car", 32'(car), 32'h0);
        rst_n   = 1'b1;
        arr_cyc = 0;
        ev_cyc  = 0;
        repeat (14) begin
            step();
            if (arrive == 15'h7FFF) arr_cyc++;
            if (any_event) ev_cyc++;
        end
        chk("t1_car", 32'(car), 32'h7FFF);
        chk("t1_arrive_cycles", 32'(arr_cyc), 32'd1);
        chk("t1_event_cycles", 32'(ev_cyc), 32'd1);

        // Empty the lot, then a clean arrival on slot 3.
        car_raw = '0;
        hold(20);
        chk("t2_empty", 32'(car), 32'h0);
        car_raw[3] = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!car[3] && lat < 30);
        chk("t2_latency_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        chk("t2_other_bits", 32'(car & ~15'h0008), 32'h0);
        hold(3);

        // Bouncy arrival on slot 7.
        car_raw[7] = 1'b1;
        hold(8);
        car_raw[7] = 1'b0;
        hold(4);
        car_raw[7] = 1'b1;
        hold(16);
        chk("t3_car7", 32'(car[7]), 32'd1);

        // Short glitch on slot 0.
        car_raw[0] = 1'b1;
        hold(5);
        car_raw[0] = 1'b0;
        seen = 0;
        repeat (20) begin
            step();
            if (arrive[0] || any_event) seen++;
        end
        chk("t4_no_arrive", 32'(seen), 32'd0);
        chk("t4_car0", 32'(car[0]), 32'd0);

        // Slot 2 departs while slot 9 arrives.
        car_raw[2] = 1'b1;
        hold(20);
        car_raw[2] = 1'b0;
        car_raw[9] = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!any_event && lat < 20);
        chk("t5_pair", 32'({depart[2], arrive[9]}), 32'b11);
        step();
        chk("t5_event_1clk", 32'(any_event), 32'd0);

        // Reset after two of three disagreeing ticks on slot 5.
        car_raw[5] = 1'b1;
        lat = 0;
        while (!(hist[5][1:0] == 2'b11 && !mcar[5]) && lat < 20) begin
            step();
            lat++;
        end
        chk("t6_mid_debounce", 32'(hist[5][1:0] == 2'b11 && !car[5]), 32'd1);
        async_reset(2);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!car[5] && lat < 30);
        chk("t6_full_debounce", 32'(lat), 32'd12);

        // Random bouncing on all slots with one reset midway.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) car_raw[i] = ~car_raw[i];
            if (c == 1000) async_reset($urandom_range(1, 5));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slot_sensor_filter.md
# slot_sensor_filter

Front-end conditioner for the parking-slot sensor inputs. Takes the 15 raw, asynchronous, bouncy slot sensors (switches or IR sensors on the Basys3 headers) and produces a clean, debounced occupancy vector. That vector feeds the slot-counting stage directly. The block also emits per-slot one-cycle arrival and departure pulses for gate/event logic.

## Interface
Parameters:
- N_SLOTS, 15: number of slot sensors.
- TICK_DIV, 100_000: clock cycles per sample tick (1 ms at 100 MHz); must be ≥ 2.
- STABLE_TICKS, 10: consecutive differing samples required to accept a change; must be ≥ 1.

Ports:
- clk  in  1  system clock, 100 MHz; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- car_raw  in  N_SLOTS  raw sensor levels; 1 = car present; asynchronous to clk.
- car  out  N_SLOTS  debounced occupancy, registered; feeds the slot counter.
- arrive  out  N_SLOTS  1-cycle pulse per bit on accepted 0→1 of car[i].
- depart  out  N_SLOTS  1-cycle pulse per bit on accepted 1→0 of car[i].
- event  out  1  OR of all arrive and depart bits, registered with them.

## Operation
- Synchronizer: each car_raw bit passes through a 2-flop synchronizer (sync[i]). Reset value is 0.
- Prescaler: a shared counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly one clk cycle, when the counter equals TICK_DIV-1.
  - This gives one tick per TICK_DIV cycles.
- Per-slot debounce cell: a counter cnt of width clog2(STABLE_TICKS+1). It updates only on tick cycles:
  - If sync[i] == car[i]: cnt ← 0.
  - If sync[i] != car[i] and cnt == STABLE_TICKS-1: car[i] ← sync[i], cnt ← 0, and pulse arrive[i] or depart[i] per direction.
  - Otherwise: cnt ← cnt+1.
- A glitch shorter than STABLE_TICKS consecutive samples is never propagated. Any agreeing sample restarts the count.
- Slots are fully independent. Simultaneous changes on several slots produce simultaneous pulses in the same cycle. Nothing is serialised.
- No saturation issue: cnt never exceeds STABLE_TICKS-1.
- STABLE_TICKS = 1: accept on the first differing tick.
- Reset (asynchronous, any time including mid-debounce):
  - Outputs: car = 0 (all slots empty), arrive = depart = 0, event = 0.
  - Internal state: prescaler = 0, all cnt = 0, synchronizers = 0.
  - After release, a slot held occupied is accepted via the normal debounce path and produces an arrive pulse.

## Timing
- Synchronizer latency is 2 clk.
- car[i], arrive[i] and depart[i] change on the same rising edge: the edge of the STABLE_TICKS-th consecutive tick at which sync[i] differs from car[i].
- Raw-edge-to-car latency is between 2+(STABLE_TICKS-1)·TICK_DIV+1 and 2+STABLE_TICKS·TICK_DIV clk.
- arrive and depart are high for exactly 1 clk and are never both high for the same bit.
- event is high in the same cycle as any pulse.
- The first tick after reset release occurs TICK_DIV cycles later.

## Structure
- Shared package parking_pkg holds:
  - N_SLOTS = 15
  - default TICK_DIV and STABLE_TICKS
  - the clog2-derived counter widths
  - the 15-bit slot-vector type, also used by the counter and display stages
- Sub-module slot_debounce_cell: one channel, containing synchronizer, cnt, car bit and pulse generation. It is instantiated N_SLOTS times by a generate loop.
- Prescaler and event OR stay in the top level.

## Test plan
All scenarios use TICK_DIV = 4 and STABLE_TICKS = 3 unless stated.
1. Reset: hold rst_n = 0 with car_raw = 15'h7FFF → car = 0, no pulses. Release → car becomes 15'h7FFF within 2+12 clk, arrive = 15'h7FFF for exactly 1 clk, event = 1 for 1 clk.
2. Clean arrival: car_raw[3] 0→1 and held → car[3] rises 11–14 clk later, arrive[3] is a single 1-clk pulse, other bits unchanged.
3. Bounce rejection: car_raw[7] pulses high for 2 ticks, goes low 1 tick, then high → car[7] rises only after 3 consecutive high ticks following the last low sample.
4. Short glitch: car_raw[0] high for 5 clk then low → car[0] stays 0, no arrive, event stays 0.
5. Simultaneous events: slot 2 departs and slot 9 arrives on the same edge → depart[2] and arrive[9] are high in the same cycle, and event is high for 1 clk.
6. Reset mid-debounce: assert rst_n low after 2 of 3 differing ticks on slot 5 → car[5] = 0 and cnt cleared. After release, a full 3-tick debounce is required again.
